// File: rtl/dm_access_unit_pkg.sv
// ============================================================================
// Module : dm_access_unit_pkg
// Brief  : Shared access-size and FSM state encodings for the DM access unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dm_access_unit_if.sv
// ============================================================================
// Module : dm_access_unit_if
// Brief  : CPU request/response handshake plus word-addressed DM port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_access_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_pc4;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_we;
  logic [31:0]       dm_pc4;
  logic [31:0]       dm_rdata;

  // Environment side: issues requests and supplies the DM read data.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc4,
    output dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_addr, dm_wdata, dm_we, dm_pc4
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc4,
    input  dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_wdata, dm_we, dm_pc4
  );
endinterface

`default_nettype wire

// File: rtl/dm_access_unit_lane_merge_extend.sv
// ============================================================================
// Module : dm_access_unit_lane_merge_extend
// Brief  : Sub-word store merge and load lane extract / sign-zero extension.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_unit_lane_merge_extend
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  byte_off,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{byte_off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{byte_off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    w_byte = rd_word[{byte_off, 3'b000} +: 8];
    w_half = rd_word[{byte_off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: rdata = is_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: rdata = rd_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_access_unit.sv
// ============================================================================
// Module : dm_access_unit
// Brief  : Byte-addressed load/store initiator for a word-addressed data memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  dm_access_unit_if.slave bus
);
  import dm_access_unit_pkg::*;

  state_e            r_state;
  logic              r_we;
  size_e             r_size;
  logic              r_unsigned;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_pc4;
  logic [31:0]       r_word;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  size_e       w_req_size;
  logic        w_req_err;
  logic [31:0] w_merged;
  logic [31:0] w_rdata;

  assign w_req_size = size_e'(bus.req_size);

  // Reject before any DM access: reserved size, misalignment, or bytes past the DM.
  assign w_req_err = (w_req_size == SZ_RSVD)
                   | ((w_req_size == SZ_HALF) &  bus.req_addr[0])
                   | ((w_req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                   | (|bus.req_addr[31:ADDR_W+2]);

  dm_access_unit_lane_merge_extend u_lane (
    .old_word    (r_word),
    .wdata       (r_wdata),
    .size        (r_size),
    .byte_off    (r_addr[1:0]),
    .is_unsigned (r_unsigned),
    .rd_word     (bus.dm_rdata),
    .merged      (w_merged),
    .rdata       (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pc4        <= '0;
      r_word       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_size     <= w_req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr[ADDR_W+1:0];
            r_wdata    <= bus.req_wdata;
            r_pc4      <= bus.req_pc4;
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else if (bus.req_we && (w_req_size == SZ_WORD)) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          // Loads finish here; sub-word stores keep the old word for the merge.
          r_word <= bus.dm_rdata;
          if (r_we) begin
            r_state <= ST_WR;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
            r_state      <= ST_RESP;
          end
        end
        ST_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.dm_addr    = ((r_state == ST_RD) || (r_state == ST_WR)) ? r_addr[ADDR_W+1:2] : '0;
  assign bus.dm_wdata   = (r_state == ST_WR) ? w_merged : '0;
  assign bus.dm_we      = (r_state == ST_WR) && !reset;
  assign bus.dm_pc4     = r_pc4;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
// ============================================================================
// Module : tb_dm_access_unit
// Brief  : Directed self-checking bench for dm_access_unit with a behavioural DM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_access_unit;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  dm_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  dm_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.dm_rdata = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (bus.dm_we) begin
      mem[bus.dm_addr] <= bus.dm_wdata;
      we_cnt           <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc4);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_pc4      = pc4;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'h0, 32'h0);
    chk({tag, "_rd_we"}, {31'h0, bus.dm_we}, 32'h0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    @(negedge clk);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    issue(we, size, 1'b0, addr, 32'hCAFEF00D, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, bus.resp_err}, 32'h1);
    chk({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    chk({tag, "_dm_we"}, {31'h0, bus.dm_we}, 32'h0);
    @(negedge clk);
    chk({tag, "_idle"}, {30'h0, bus.req_ready, bus.resp_valid}, 32'h2);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_pc4      = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp", {29'h0, bus.resp_valid, bus.resp_err, bus.dm_we}, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_dm_addr", {22'h0, bus.dm_addr}, 32'h0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
    chk("rst_dm_pc4", bus.dm_pc4, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    mem[5] = 32'h11223344;
    mem[2] = 32'h11223344;

    // sw 0xDEADBEEF @0x10
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h3004);
    chk("sw_we", {31'h0, bus.dm_we}, 32'h1);
    chk("sw_addr", {22'h0, bus.dm_addr}, 32'h4);
    chk("sw_wdata", bus.dm_wdata, 32'hDEADBEEF);
    chk("sw_pc4", bus.dm_pc4, 32'h3004);
    chk("sw_busy", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    chk("sw_resp", {29'h0, bus.resp_valid, bus.resp_err, bus.dm_we}, 32'h4);
    @(negedge clk);
    chk("sw_idle", {30'h0, bus.req_ready, bus.resp_valid}, 32'h2);
    chk("sw_we_cnt", we_cnt, 32'd1);
    chk("sw_mem", mem[4], 32'hDEADBEEF);

    do_load("lw", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    // sb 0xAB @0x16 : read-modify-write of index 5
    issue(1'b1, 2'b00, 1'b0, 32'h16, 32'h123456AB, 32'h3010);
    chk("sb_rd_we", {31'h0, bus.dm_we}, 32'h0);
    chk("sb_rd_addr", {22'h0, bus.dm_addr}, 32'h5);
    @(negedge clk);
    chk("sb_wr_we", {31'h0, bus.dm_we}, 32'h1);
    chk("sb_wr_data", bus.dm_wdata, 32'h11AB3344);
    @(negedge clk);
    chk("sb_resp", {31'h0, bus.resp_valid}, 32'h1);
    @(negedge clk);
    chk("sb_we_cnt", we_cnt, 32'd2);
    do_load("lb", 2'b00, 1'b0, 32'h16, 32'hFFFFFFAB);
    do_load("lbu", 2'b00, 1'b1, 32'h16, 32'h000000AB);

    // sh 0x8001 @0x0A : upper half of index 2
    issue(1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF8001, 32'h3020);
    chk("sh_rd_we", {31'h0, bus.dm_we}, 32'h0);
    @(negedge clk);
    chk("sh_wr_we", {31'h0, bus.dm_we}, 32'h1);
    chk("sh_wr_data", bus.dm_wdata, 32'h80013344);
    @(negedge clk);
    @(negedge clk);
    chk("sh_we_cnt", we_cnt, 32'd3);
    do_load("lh", 2'b01, 1'b0, 32'h0A, 32'hFFFF8001);
    do_load("lhu", 2'b01, 1'b1, 32'h0A, 32'h00008001);

    do_err("err_lw_mis", 1'b0, 2'b10, 32'h02);
    do_err("err_sh_mis", 1'b1, 2'b01, 32'h03);
    do_err("err_rsvd", 1'b1, 2'b11, 32'h00);
    do_err("err_range", 1'b0, 2'b10, 32'h1000);
    chk("err_we_cnt", we_cnt, 32'd3);

    // Reset during the RD cycle of an sb
    issue(1'b1, 2'b00, 1'b0, 32'h16, 32'h00000055, 32'h3030);
    reset = 1'b1;
    chk("rmid_we0", {31'h0, bus.dm_we}, 32'h0);
    @(negedge clk);
    chk("rmid_we1", {31'h0, bus.dm_we}, 32'h0);
    chk("rmid_valid1", {31'h0, bus.resp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rmid_we2", {30'h0, bus.dm_we, bus.resp_valid}, 32'h0);
    @(negedge clk);
    chk("rmid_we3", {30'h0, bus.dm_we, bus.resp_valid}, 32'h0);
    chk("rmid_we_cnt", we_cnt, 32'd3);
    chk("rmid_mem", mem[5], 32'h11AB3344);

    // Back-to-back: req_valid held high across a word store and a load
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h20;
    bus.req_wdata    = 32'h12345678;
    bus.req_pc4      = 32'h4000;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    chk("b2b_t1_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("b2b_t1_we", {31'h0, bus.dm_we}, 32'h1);
    chk("b2b_t1_addr", {22'h0, bus.dm_addr}, 32'h8);
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("b2b_t2_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("b2b_t2_valid", {31'h0, bus.resp_valid}, 32'h1);
    @(negedge clk);
    chk("b2b_t3_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("b2b_t3_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_ld_busy", {31'h0, bus.req_ready}, 32'h0);
    chk("b2b_ld_addr", {22'h0, bus.dm_addr}, 32'h8);
    chk("b2b_ld_we", {31'h0, bus.dm_we}, 32'h0);
    @(negedge clk);
    chk("b2b_ld_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("b2b_ld_rdata", bus.resp_rdata, 32'h12345678);
    @(negedge clk);
    chk("b2b_we_cnt", we_cnt, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
